// File: rtl/sle_bank_loader.sv
// Command-to-pulse control stage for a bank of SLE register cells, with settle-then-readback response.
// Optional verify/retry logic is enabled by defining SLE_LOADER_VERIFY_EN.
module sle_bank_loader #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] sle_en,
  output logic             sle_sln,
  output logic             sle_sd,
  output logic [WIDTH-1:0] sle_d,
  input  logic [WIDTH-1:0] sle_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] data_r;
  logic [CW-1:0]    wait_cnt;
  logic             retry_inc;

`ifdef SLE_LOADER_VERIFY_EN
  logic [3:0]       retry_cnt;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             rsp_err_r;

  always_comb begin
    expected = '0;
    case (op_r)
      OP_LOAD:  expected = data_r;
      OP_SET:   expected = '1;
      OP_CLEAR: expected = '0;
      default:  expected = sle_q;
    endcase
  end

  // READ never drives the bank, so it can never fail verification.
  assign mismatch = (op_r != OP_READ) && (|((sle_q ^ expected) & mask_r));
  assign rsp_err  = rsp_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
      rsp_err_r <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
      if (state == S_CHECK) begin
        rsp_err_r <= mismatch;
      end
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_op == OP_READ) ? S_CHECK : S_DRIVE;
        end
      end
      S_DRIVE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == CW'(SETTLE_CYC - 1)) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nxt = S_RESP;
`ifdef SLE_LOADER_VERIFY_EN
        if (mismatch && (retry_cnt < 4'(MAX_RETRY))) begin
          state_nxt = S_DRIVE;
          retry_inc = 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      mask_r   <= '0;
      data_r   <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && cmd_valid) begin
        op_r   <= cmd_op;
        mask_r <= cmd_mask;
        data_r <= cmd_data;
      end
      wait_cnt <= (state == S_WAIT) ? CW'(wait_cnt + 1'b1) : '0;
      if (state == S_CHECK) begin
        rsp_data <= sle_q;
      end
    end
  end

  // Bank controls are only non-zero for the single DRIVE cycle.
  assign sle_en    = (state == S_DRIVE) ? mask_r : '0;
  assign sle_d     = (state == S_DRIVE) ? data_r : '0;
  assign sle_sln   = (state == S_DRIVE) && (op_r == OP_LOAD);
  assign sle_sd    = (state == S_DRIVE) && (op_r == OP_SET);
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule
